// File: rtl/rc522_reg_ctrl_pkg.sv
// Shared types and constants for the RC522 register-access sequencer:
// FSM states, SPI address-byte encoding and the RC522 register map used by init/poll.
package rc522_reg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_GAP     = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  localparam logic [7:0] RC522_RD_BIT    = 8'h80;
  localparam logic [7:0] RC522_ADDR_MASK = 8'h7E;

  localparam logic [5:0] TX_MODE_REG     = 6'h12;
  localparam logic [5:0] RX_MODE_REG     = 6'h13;
  localparam logic [5:0] TX_CONTROL_REG  = 6'h14;
  localparam logic [5:0] TX_ASK_REG      = 6'h15;
  localparam logic [5:0] MOD_WIDTH_REG   = 6'h24;
  localparam logic [5:0] T_MODE_REG      = 6'h2A;
  localparam logic [5:0] T_PRESCALER_REG = 6'h2B;

  // RC522 SPI address byte: bit 7 = read, bits 6:1 = register, bit 0 = 0.
  function automatic logic [7:0] rc522_addr_byte(input logic is_write, input logic [5:0] addr);
    logic [7:0] shifted;
    shifted = {1'b0, addr, 1'b0} & RC522_ADDR_MASK;
    return is_write ? shifted : (shifted | RC522_RD_BIT);
  endfunction

endpackage

// File: rtl/rc522_reg_ctrl_wait_timer.sv
// Shared wait counter: cleared on every phase change, saturates at SAT_CYCLES,
// flags both the busy timeout and the last cycle of the inter-byte gap.
module rc522_reg_ctrl_wait_timer #(
  parameter int unsigned TW         = 28,
  parameter int unsigned SAT_CYCLES = 200_000_000,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired,
  output logic gap_done
);

  localparam logic [TW-1:0] SAT_VAL  = TW'(SAT_CYCLES);
  localparam logic [TW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : TW'(GAP_CYCLES - 1);

  logic [TW-1:0] count_q;

  assign expired  = (count_q == SAT_VAL);
  assign gap_done = (count_q == GAP_LAST);

  always_ff @(posedge CLOCK_50) begin
    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    if (reset || clear) begin
      count_q <= '0;
    end else if (count_en && !expired) begin
      count_q <= count_q + TW'(1);
    end
  end

endmodule

// File: rtl/rc522_reg_ctrl.sv
// RC522 register access sequencer: one req/rsp transaction becomes an address byte
// and a data/dummy byte on spi_master, each guarded by a busy timeout.
module rc522_reg_ctrl
  import rc522_reg_ctrl_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  parameter int unsigned TW             = 28
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       spi_start_n,
  output logic [7:0] spi_data_in,
  input  logic       spi_busy,
  input  logic [7:0] spi_data_out
);

  state_e     state_q, state_d;
  logic       byte_sel_q;
  logic       write_q;
  logic [7:0] wdata_q;

  logic       accept;
  logic       timeout_hit;
  logic       load_byte1;
  logic       tmr_clear, tmr_count, tmr_expired, tmr_gap_done;

  assign req_ready   = (state_q == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign rsp_valid   = (state_q == ST_RESP);
  // Start stays low for the whole WAIT_HI phase so a slow master cannot miss it.
  assign spi_start_n = (state_q != ST_WAIT_HI);

  rc522_reg_ctrl_wait_timer #(
    .TW         (TW),
    .SAT_CYCLES (TIMEOUT_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_wait_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (tmr_clear),
    .count_en (tmr_count),
    .expired  (tmr_expired),
    .gap_done (tmr_gap_done)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    tmr_clear   = 1'b0;
    tmr_count   = 1'b0;
    timeout_hit = 1'b0;
    load_byte1  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d   = ST_WAIT_HI;
        tmr_clear = 1'b1;
      end
      ST_WAIT_HI: begin
        if (spi_busy) begin
          state_d   = ST_WAIT_LO;
          tmr_clear = 1'b1;
        end else if (tmr_expired) begin
          state_d     = ST_RESP;
          timeout_hit = 1'b1;
        end else begin
          tmr_count = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!spi_busy) begin
          tmr_clear = 1'b1;
          if (byte_sel_q) begin
            state_d = ST_RESP;
          end else if (GAP_CYCLES == 0) begin
            state_d    = ST_LOAD;
            load_byte1 = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end else if (tmr_expired) begin
          state_d     = ST_RESP;
          timeout_hit = 1'b1;
        end else begin
          tmr_count = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_gap_done) begin
          state_d    = ST_LOAD;
          load_byte1 = 1'b1;
        end else begin
          tmr_count = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_sel_q  <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      spi_data_in <= 8'h00;
      rsp_rdata   <= 8'h00;
      rsp_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q     <= req_write;
        wdata_q     <= req_wdata;
        byte_sel_q  <= 1'b0;
        spi_data_in <= rc522_addr_byte(req_write, req_addr);
      end
      if (load_byte1) begin
        byte_sel_q  <= 1'b1;
        spi_data_in <= write_q ? wdata_q : 8'h00;
      end
      // Response fields update as RESP is entered and hold until the next response.
      if (state_d == ST_RESP) begin
        rsp_err   <= timeout_hit;
        rsp_rdata <= (!timeout_hit && byte_sel_q && !write_q) ? spi_data_out : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_rc522_reg_ctrl.sv
// Self-checking bench for rc522_reg_ctrl: table vectors, hand-written corner sequences
// and random accesses against an spi_master slave model and a transaction-level reference.
module tb_rc522_reg_ctrl;
  import rc522_reg_ctrl_pkg::*;

  localparam int GAP     = 16;
  localparam int TIMEOUT = 100;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       spi_start_n, spi_busy;
  logic [7:0] spi_data_in, spi_data_out;

  rc522_reg_ctrl #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TW             (28)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .spi_start_n  (spi_start_n),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_data_out (spi_data_out)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // spi_master model: sees start low, raises busy after hi_delay, holds it busy_len cycles.
  logic       slave_en;
  int         hi_delay, busy_len;
  logic [7:0] miso_q[$];
  logic [7:0] sent_q[$];

  initial begin
    spi_busy     = 1'b0;
    spi_data_out = 8'h00;
    forever begin
      @(negedge CLOCK_50);
      if (slave_en && spi_start_n == 1'b0 && !spi_busy) begin
        sent_q.push_back(spi_data_in);
        repeat (hi_delay) @(negedge CLOCK_50);
        spi_busy = 1'b1;
        repeat (busy_len) @(negedge CLOCK_50);
        spi_data_out = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hEE;
        spi_busy     = 1'b0;
      end
    end
  end

  int start_lo_cnt = 0;
  always @(negedge CLOCK_50) if (spi_start_n == 1'b0) start_lo_cnt <= start_lo_cnt + 1;

  // Reference: RC522 byte format and the accept-to-response cycle count.
  function automatic logic [7:0] model_addr_byte(input logic w, input logic [5:0] a);
    int v;
    v = int'(a) * 2;
    if (!w) v = v + 128;
    return 8'(v);
  endfunction

  function automatic int model_latency(input int h, input int b);
    return 2 * (1 + (h + 1) + b) + GAP + 1;
  endfunction

  task automatic send_req(input logic w, input logic [5:0] a, input logic [7:0] d,
                          input logic [7:0] m1, input int h, input int b,
                          output int lat, output logic [7:0] rd, output logic er);
    int n;
    sent_q.delete();
    miso_q.delete();
    miso_q.push_back(8'hC3);
    miso_q.push_back(m1);
    hi_delay = h;
    busy_len = b;
    @(negedge CLOCK_50);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 3000) begin
      @(negedge CLOCK_50);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  typedef struct {
    logic       w;
    logic [5:0] a;
    logic [7:0] d;
    logic [7:0] miso;
    logic [7:0] eb0;
    logic [7:0] eb1;
    logic [7:0] erd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         lat, n, gap, s0;
    logic [7:0] rd;
    logic       er;
    bit         ready_seen;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 6'h00; req_wdata = 8'h00;
    slave_en = 1'b1; hi_delay = 0; busy_len = 8;

    vecs[0] = '{1'b1, TX_MODE_REG,    8'h00, 8'h00, 8'h24, 8'h00, 8'h00};
    vecs[1] = '{1'b0, TX_CONTROL_REG, 8'h00, 8'h80, 8'hA8, 8'h00, 8'h80};
    vecs[2] = '{1'b1, 6'h3F,          8'hFF, 8'h11, 8'h7E, 8'hFF, 8'h00};
    vecs[3] = '{1'b0, 6'h00,          8'h99, 8'h5A, 8'h80, 8'h00, 8'h5A};
    vecs[4] = '{1'b1, MOD_WIDTH_REG,  8'h26, 8'h00, 8'h48, 8'h26, 8'h00};
    vecs[5] = '{1'b0, 6'h3F,          8'h00, 8'h01, 8'hFE, 8'h00, 8'h01};

    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset req_ready",   32'(req_ready),   32'h1);
    check("reset rsp_valid",   32'(rsp_valid),   32'h0);
    check("reset rsp_err",     32'(rsp_err),     32'h0);
    check("reset rsp_rdata",   32'(rsp_rdata),   32'h0);
    check("reset spi_start_n", 32'(spi_start_n), 32'h1);
    check("reset spi_data_in", 32'(spi_data_in), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].miso, 0, 8, lat, rd, er);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(model_latency(0, 8)));
      check($sformatf("vec%0d nbytes", i), 32'(sent_q.size()), 32'd2);
      if (sent_q.size() == 2) begin
        check($sformatf("vec%0d byte0", i), 32'(sent_q[0]), 32'(vecs[i].eb0));
        check($sformatf("vec%0d byte1", i), 32'(sent_q[1]), 32'(vecs[i].eb1));
      end
      check($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].erd));
      check($sformatf("vec%0d err", i), 32'(er), 32'h0);
      @(negedge CLOCK_50);
      check($sformatf("vec%0d pulse", i), 32'(rsp_valid), 32'h0);
    end
    repeat (4) @(negedge CLOCK_50);
    check("rdata held", 32'(rsp_rdata), 32'h01);

    // Busy never rises: timeout in WAIT_HI.
    slave_en = 1'b0;
    s0 = start_lo_cnt;
    send_req(1'b1, T_MODE_REG, 8'h8D, 8'h00, 0, 1, lat, rd, er);
    check("to_hi latency", 32'(lat), 32'd103);
    check("to_hi err", 32'(er), 32'h1);
    check("to_hi rdata", 32'(rd), 32'h0);
    check("to_hi start_n at rsp", 32'(spi_start_n), 32'h1);
    repeat (20) @(negedge CLOCK_50);
    check("to_hi start low cycles", 32'(start_lo_cnt - s0), 32'd101);
    slave_en = 1'b1;

    // Busy stuck high: timeout in WAIT_LO, no second byte.
    send_req(1'b0, RX_MODE_REG, 8'h00, 8'h77, 0, 400, lat, rd, er);
    check("to_lo latency", 32'(lat), 32'd104);
    check("to_lo err", 32'(er), 32'h1);
    check("to_lo rdata", 32'(rd), 32'h0);
    n = 0;
    do begin @(negedge CLOCK_50); #1; n++; end while (spi_busy && n < 1000);
    check("to_lo busy released", 32'(spi_busy), 32'h0);
    repeat (5) @(negedge CLOCK_50);
    check("to_lo one byte", 32'(sent_q.size()), 32'd1);

    // Back-to-back with req_valid held.
    sent_q.delete(); miso_q.delete();
    hi_delay = 1; busy_len = 2;
    @(negedge CLOCK_50);
    req_write = 1'b1; req_addr = T_MODE_REG; req_wdata = 8'h80; req_valid = 1'b1;
    check("b2b first ready", 32'(req_ready), 32'h1);
    @(negedge CLOCK_50);
    req_addr = T_PRESCALER_REG; req_wdata = 8'hA9;
    ready_seen = 1'b0;
    n = 0;
    while (!rsp_valid && n < 500) begin
      if (req_ready) ready_seen = 1'b1;
      @(negedge CLOCK_50);
      n++;
    end
    check("b2b first rsp", 32'(rsp_valid), 32'h1);
    check("b2b ready low during first", 32'(ready_seen || req_ready), 32'h0);
    @(negedge CLOCK_50);
    check("b2b ready after rsp", 32'(req_ready), 32'h1);
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge CLOCK_50); n++; end
    check("b2b second rsp", 32'(rsp_valid), 32'h1);
    check("b2b nbytes", 32'(sent_q.size()), 32'd4);
    if (sent_q.size() == 4)
      check("b2b stream", {sent_q[0], sent_q[1], sent_q[2], sent_q[3]}, 32'h548056A9);

    // Reset during byte-1 WAIT_LO abandons the access.
    sent_q.delete(); miso_q.delete();
    hi_delay = 0; busy_len = 30;
    @(negedge CLOCK_50);
    req_write = 1'b0; req_addr = RX_MODE_REG; req_valid = 1'b1;
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge CLOCK_50); #1; n++; end while (!(sent_q.size() == 2 && spi_busy) && n < 200);
    check("rst reached byte1", 32'(n < 200), 32'h1);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("rst req_ready", 32'(req_ready), 32'h1);
    check("rst start_n", 32'(spi_start_n), 32'h1);
    check("rst rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst data_in", 32'(spi_data_in), 32'h0);
    reset = 1'b0;
    s0 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLOCK_50);
      if (rsp_valid) s0++;
    end
    check("rst no rsp", 32'(s0), 32'h0);

    // Inter-byte gap length.
    sent_q.delete(); miso_q.delete();
    hi_delay = 0; busy_len = 3;
    @(negedge CLOCK_50);
    req_write = 1'b1; req_addr = TX_ASK_REG; req_wdata = 8'h40; req_valid = 1'b1;
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge CLOCK_50); #1; n++; end while (!spi_busy && n < 100);
    do begin @(negedge CLOCK_50); #1; n++; end while (spi_busy && n < 200);
    check("gap byte0 done", 32'(n < 200), 32'h1);
    gap = 0;
    @(negedge CLOCK_50);
    while (spi_start_n && spi_data_in == 8'h2A && gap < 100) begin
      gap++;
      @(negedge CLOCK_50);
    end
    check("gap cycles", 32'(gap), 32'(GAP));
    check("gap load byte1", 32'(spi_data_in), 32'h40);
    check("gap load start_n", 32'(spi_start_n), 32'h1);
    @(negedge CLOCK_50);
    check("gap byte1 start", 32'(spi_start_n), 32'h0);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge CLOCK_50); n++; end
    check("gap rsp", 32'(rsp_valid), 32'h1);

    // Random accesses against the reference model.
    for (int i = 0; i < 20; i++) begin
      logic       w;
      logic [5:0] a;
      logic [7:0] d, m;
      int         h, b;
      w = 1'($urandom_range(0, 1));
      a = 6'($urandom_range(0, 63));
      d = 8'($urandom_range(0, 255));
      m = 8'($urandom_range(0, 255));
      h = int'($urandom_range(0, 3));
      b = int'($urandom_range(1, 5));
      send_req(w, a, d, m, h, b, lat, rd, er);
      check($sformatf("rnd%0d latency", i), 32'(lat), 32'(model_latency(h, b)));
      check($sformatf("rnd%0d nbytes", i), 32'(sent_q.size()), 32'd2);
      if (sent_q.size() == 2) begin
        check($sformatf("rnd%0d byte0", i), 32'(sent_q[0]), 32'(model_addr_byte(w, a)));
        check($sformatf("rnd%0d byte1", i), 32'(sent_q[1]), 32'(w ? d : 8'h00));
      end
      check($sformatf("rnd%0d rdata", i), 32'(rd), 32'(w ? 8'h00 : m));
      check($sformatf("rnd%0d err", i), 32'(er), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
